// File: rtl/rat_int_ctrl_if.sv
// RAT MCU I/O bus as seen by a peripheral.
// The master modport is the MCU side, which drives the port ID, the output data
// and the strobe. The slave modport is a peripheral that decodes the bus and
// returns data for the wrapper's input mux.
interface rat_int_ctrl_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_DATA;
    logic       IN_SEL;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  IN_DATA,
        input  IN_SEL
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output IN_DATA,
        output IN_SEL
    );
endinterface

// File: rtl/rat_int_ctrl.sv
// Interrupt controller for the single interrupt input of the RAT MCU.
//
// Operation:
//  - Latches a rising edge on any of N_SRC request lines as a pending bit.
//  - Masks the pending bits, then picks the lowest pending index.
//  - Drives INTR high for PULSE_LEN cycles.
//  - Waits for firmware to write ACK_ID before it raises another interrupt.
//
// Optional build macro RAT_INTC_TIMEOUT_EN: if nothing acknowledges the
// interrupt within TIMEOUT cycles, the controller gives up and returns to idle.
// The source stays pending, so it re-fires. The controller also sets a sticky
// timeout flag, which reads back as STATUS bit 5.
module rat_int_ctrl #(
    parameter int         N_SRC     = 4,
    parameter int         PULSE_LEN = 4,
    parameter logic [7:0] MASK_ID   = 8'h42,
    parameter logic [7:0] ACK_ID    = 8'h43,
    parameter logic [7:0] STATUS_ID = 8'h21,
    parameter logic [7:0] PEND_ID   = 8'h22,
    parameter int         TIMEOUT   = 1024
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic             INTR,
    rat_int_ctrl_if.slave    io
);
    localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_ACK} state_t;

    state_t             state_reg;
    logic [N_SRC-1:0]   irq_prev_reg;
    logic [N_SRC-1:0]   pending_reg;
    logic [N_SRC-1:0]   pending_next;
    logic [N_SRC-1:0]   mask_reg;
    logic [N_SRC-1:0]   irq_edge;
    logic [N_SRC-1:0]   ack_clear;
    logic [N_SRC-1:0]   eligible;
    logic               strb_prev_reg;
    logic               overrun_reg;
    logic               intr_reg;
    logic [2:0]         svc_reg;
    logic [2:0]         svc_pick;
    logic [CNT_W-1:0]   pulse_cnt_reg;
    logic               strb_rise;
    logic               mask_wr;
    logic               ack_wr;
    logic               busy;
    logic               timeout_bit;
    logic [7:0]         in_data_next;
    logic               in_sel_next;
    logic               unused_out_bits;

    // Only the low N_SRC bits of the output data are ever used.
    assign unused_out_bits = ^io.OUT_PORT;

    // One action per strobe: the write acts only on the 0->1 edge of IO_STRB.
    assign strb_rise = io.IO_STRB & ~strb_prev_reg;
    assign mask_wr   = strb_rise && (io.PORT_ID == MASK_ID);
    assign ack_wr    = strb_rise && (io.PORT_ID == ACK_ID) && (state_reg != S_IDLE);
    assign eligible  = pending_reg & mask_reg;
    assign busy      = (state_reg != S_IDLE);
    assign INTR      = intr_reg;

    // Per source: edge detect, ack clear, and a new edge beating a same-cycle ack.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign irq_edge[gi]     = IRQ_IN[gi] & ~irq_prev_reg[gi];
            assign ack_clear[gi]    = ack_wr && (svc_reg == 3'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~ack_clear[gi]) | irq_edge[gi];
        end
    endgenerate

    // Priority pick: the lowest eligible index wins.
    always_comb begin
        svc_pick = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                svc_pick = 3'(i);
            end
        end
    end

    // Edge history, pending bits, mask register and sticky overrun flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_prev_reg  <= '0;
            strb_prev_reg <= 1'b0;
            pending_reg   <= '0;
            mask_reg      <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            irq_prev_reg  <= IRQ_IN;
            strb_prev_reg <= io.IO_STRB;
            pending_reg   <= pending_next;
            if (mask_wr) begin
                mask_reg <= io.OUT_PORT[N_SRC-1:0];
            end
            // A new overrun in the same cycle as an ack must not be lost.
            if (|(irq_edge & pending_reg)) begin
                overrun_reg <= 1'b1;
            end else if (ack_wr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef RAT_INTC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            to_flag_reg;
    assign timeout_bit = to_flag_reg;
`else
    assign timeout_bit = 1'b0;
`endif

    // Service FSM: latch the winner, pulse INTR, then hold off until acknowledged.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= S_IDLE;
            intr_reg      <= 1'b0;
            svc_reg       <= '0;
            pulse_cnt_reg <= '0;
`ifdef RAT_INTC_TIMEOUT_EN
            to_cnt_reg    <= '0;
            to_flag_reg   <= 1'b0;
`endif
        end else if (ack_wr) begin
            state_reg <= S_IDLE;
            intr_reg  <= 1'b0;
`ifdef RAT_INTC_TIMEOUT_EN
            to_flag_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|eligible) begin
                        svc_reg       <= svc_pick;
                        state_reg     <= S_ASSERT;
                        intr_reg      <= 1'b1;
                        pulse_cnt_reg <= CNT_W'(PULSE_LEN - 1);
                    end
                end
                S_ASSERT: begin
                    if (pulse_cnt_reg == '0) begin
                        state_reg <= S_WAIT_ACK;
                        intr_reg  <= 1'b0;
`ifdef RAT_INTC_TIMEOUT_EN
                        to_cnt_reg <= '0;
`endif
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
                    end
                end
                S_WAIT_ACK: begin
`ifdef RAT_INTC_TIMEOUT_EN
                    if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                        state_reg   <= S_IDLE;
                        to_flag_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg <= S_IDLE;
                    intr_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Read mux for the wrapper's input port, combinational from PORT_ID.
    always_comb begin
        in_data_next = '0;
        in_sel_next  = 1'b0;
        if (io.PORT_ID == STATUS_ID) begin
            in_sel_next  = 1'b1;
            in_data_next = {busy, overrun_reg, timeout_bit, 2'b00, svc_reg};
        end else if (io.PORT_ID == PEND_ID) begin
            in_sel_next                 = 1'b1;
            in_data_next[N_SRC-1:0]     = pending_reg;
        end
    end

    assign io.IN_DATA = in_data_next;
    assign io.IN_SEL  = in_sel_next;

endmodule

// File: doc/rat_int_ctrl.md
Name: rat_int_ctrl

Overview:
- Interrupt controller for the RAT MCU's single interrupt input.
- Latches rising edges from up to 8 sources, such as debounced buttons and timers.
- Applies a software-writable mask and picks the highest-priority pending source.
- Drives a fixed-length interrupt pulse to the MCU, then holds off further interrupts until firmware acknowledges through an OUTPUT port write.
- Sits in the wrapper between the source logic and the MCU interrupt pin, and decodes its own port IDs on the MCU I/O bus.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8); bit 0 has the highest priority.
- PULSE_LEN, 4, CLK cycles that INTR is held high (≥2 so the half-rate MCU clock samples it).
- MASK_ID, 8'h42, output port ID that writes the mask register.
- ACK_ID, 8'h43, output port ID that acknowledges the in-service source.
- STATUS_ID, 8'h21, input port ID that reads the status byte.
- PEND_ID, 8'h22, input port ID that reads the pending register.
- TIMEOUT, 1024, CLK cycles allowed in WAIT_ACK (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state is updated on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IRQ_IN  in  N_SRC  interrupt requests, already synchronous to CLK; rising edge = request.
- PORT_ID  in  8  MCU port ID.
- OUT_PORT  in  8  MCU output data.
- IO_STRB  in  1  MCU output strobe (may stay high for several CLK cycles).
- IN_DATA  out  8  read data for the wrapper's input mux.
- IN_SEL  out  1  high when PORT_ID equals STATUS_ID or PEND_ID.
- INTR  out  1  interrupt to the MCU.

Behaviour:
- Reset (RST_N low, asynchronous): all registers clear.
  - state=IDLE, INTR=0, pending=0, mask=0 (all sources disabled), in-service index=0, busy=0, overrun=0.
  - Edge-detect history for IRQ_IN and IO_STRB also clears.
  - An interrupt in progress is simply abandoned.
- Edge detect:
  - pending[i] sets on the cycle after IRQ_IN[i] goes 0→1, whether or not the source is masked.
  - If an edge arrives while pending[i] is already 1, the sticky overrun bit sets.
- Write decode:
  - A write is accepted on the first CLK cycle of IO_STRB high (0→1 detect), so there is exactly one action per strobe.
  - MASK_ID write: mask <= OUT_PORT[N_SRC-1:0]; takes effect on the next cycle.
  - ACK_ID write: ignored unless the state is WAIT_ACK or ASSERT. When accepted, it clears pending[in-service index], clears overrun, and moves to IDLE (an ACK during ASSERT also ends the pulse immediately).
  - Writes to any other port ID are ignored.
- Arbitration: eligible = pending & mask. In IDLE with eligible≠0, the lowest set index is latched as the in-service index.
- FSM:
  - IDLE → ASSERT when eligible≠0; INTR rises on the following cycle.
  - ASSERT: INTR=1 for exactly PULSE_LEN cycles (down-counter), then → WAIT_ACK with INTR=0.
  - WAIT_ACK: remain here until an ACK write, then → IDLE.
  - busy=1 in ASSERT and WAIT_ACK.
- Spacing: the earliest next INTR is 2 cycles after the ACK (IDLE evaluation, then ASSERT entry).
- Simultaneous events:
  - An edge on source i in the same cycle an ACK clears pending[i]: set wins, pending[i] stays 1.
  - Mask changes during ASSERT or WAIT_ACK do not affect the latched in-service source.
  - Unmasking a source that is already pending triggers arbitration on the next IDLE cycle.
- Read mux (combinational from PORT_ID):
  - STATUS_ID returns {busy, overrun, 3'b0, in-service index[2:0]}.
  - PEND_ID returns pending, zero-extended to 8 bits.
  - Any other ID returns IN_DATA=0 and IN_SEL=0.

Optional Feature:
- Macro: RAT_INTC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - After TIMEOUT cycles with no ACK, the FSM returns to IDLE and leaves pending[in-service index] set, so the source re-fires.
  - A sticky timeout flag is set and read as STATUS bit 5; an ACK write clears it.
- Undefined: no counter exists, WAIT_ACK waits indefinitely, and STATUS bit 5 reads 0.

Test Plan:
- Reset, then write MASK_ID=8'h0F, then pulse IRQ_IN[2] → INTR high for exactly 4 cycles; STATUS reads 8'h82; PEND reads 8'h04.
- IRQ_IN[1] and IRQ_IN[3] rise in the same cycle, mask=8'h0F → first INTR services index 1 (STATUS=8'h81). After the ACK, INTR fires again within 2 cycles with STATUS=8'h83.
- mask=8'h00, pulse IRQ_IN[0] → no INTR and PEND=8'h01. Then write MASK_ID=8'h01 → INTR rises within 2 cycles.
- While in WAIT_ACK on source 0, pulse IRQ_IN[0] again → STATUS=8'hC0 (overrun set). After ACK, pending[0] is cleared and overrun is cleared.
- Drive IO_STRB high for 6 cycles with PORT_ID=ACK_ID → exactly one ACK. Drop RST_N during ASSERT → INTR=0 immediately; PEND=8'h00; mask=8'h00.
- With RAT_INTC_TIMEOUT_EN and TIMEOUT=16, send no ACK → the FSM returns to IDLE after 16 cycles, STATUS bit 5=1, and INTR re-asserts for the same source.
